// File: rtl/stack_seq_pkg.sv
// stack_seq_pkg: op codes, FSM states and select constants for stack_sequencer
package stack_seq_pkg;
  typedef enum logic [1:0] {OP_CALL = 2'b00, OP_RET = 2'b01, OP_INT = 2'b10, OP_RTI = 2'b11} op_e;
  typedef enum logic [2:0] {
    IDLE, PUSH_PC_HI, PUSH_PC_LO, PUSH_FLAGS, POP_FLAGS, POP_PC_LO, POP_PC_HI, RESTORE
  } state_e;
  localparam logic [1:0] ADDR_NONE = 2'b00;
  localparam logic [1:0] ADDR_SP = 2'b10;
  localparam logic [1:0] SRC_FLAGS = 2'b00;
  localparam logic [1:0] SRC_PC_HI = 2'b01;
  localparam logic [1:0] SRC_PC_LO = 2'b10;
  function automatic state_e first_state(input op_e op);
    return op == OP_RET ? POP_PC_LO : op == OP_RTI ? POP_FLAGS : PUSH_PC_HI;
  endfunction
endpackage

// File: rtl/stack_sequencer.sv
// stack_sequencer: expands CALL/RET/INT/RTI and irq into one-word stack push/pop cycles
// Ports: op_valid/op_code/op_ready request handshake, irq interrupt pulse, pc/flags return context,
// mem_data pop data; memory_* controls and selects, interrupt/pc_choose_memory/flags_restore redirect,
// restored_pc/restored_flags popped context, stall, stack_fault.
// Optional depth tracking with fault on overflow/underflow: STACK_SEQ_OVERFLOW_CHECK_EN.
module stack_sequencer
  import stack_seq_pkg::*;
#(
  parameter int STACK_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [1:0]  op_code,
  output logic        op_ready,
  input  logic        irq,
  input  logic [31:0] pc,
  input  logic [2:0]  flags,
  input  logic [15:0] mem_data,
  output logic        memory_read,
  output logic        memory_write,
  output logic        memory_push,
  output logic        memory_pop,
  output logic [1:0]  memory_address_select,
  output logic [1:0]  memory_write_src_select,
  output logic        interrupt,
  output logic        pc_choose_memory,
  output logic [31:0] restored_pc,
  output logic [2:0]  restored_flags,
  output logic        flags_restore,
  output logic        stall,
  output logic        stack_fault
);
  state_e state, state_n;
  op_e op_q, start_op;
  logic pend_q, irq_pending, start_irq, start, fault_n;
  // The pushed words themselves come from the memory stage; only the source select is driven here.
  logic unused_ctx;
  assign unused_ctx = ^{pc, flags};
  // A raw irq counts as pending in its own cycle so it wins over a simultaneous op_valid.
  assign irq_pending = pend_q | irq;
  assign op_ready = state == IDLE && !irq_pending && !reset;
  assign start_irq = state == IDLE && irq_pending;
  assign start = start_irq | (op_valid & op_ready);
  assign start_op = start_irq ? OP_INT : op_e'(op_code);
`ifdef STACK_SEQ_OVERFLOW_CHECK_EN
  localparam int DW = $clog2(STACK_DEPTH + 1);
  localparam logic [DW-1:0] DMAX = DW'(STACK_DEPTH);
  logic [DW-1:0] depth, need;
  assign need = start_op inside {OP_CALL, OP_RET} ? DW'(2) : DW'(3);
  assign fault_n = start && (start_op inside {OP_CALL, OP_INT} ? DMAX - depth < need : depth < need);
  always_ff @(posedge clk)
    depth <= reset ? '0 : memory_push ? depth + DW'(1) : memory_pop ? depth - DW'(1) : depth;
`else
  localparam int unused_depth = STACK_DEPTH;
  assign fault_n = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      op_q <= OP_CALL;
      pend_q <= 1'b0;
      restored_pc <= '0;
      restored_flags <= '0;
      stack_fault <= 1'b0;
    end else begin
      state <= state_n;
      op_q <= start ? start_op : op_q;
      pend_q <= start_irq ? 1'b0 : irq_pending;
      restored_pc[15:0] <= state == POP_PC_LO ? mem_data : restored_pc[15:0];
      restored_pc[31:16] <= state == POP_PC_HI ? mem_data : restored_pc[31:16];
      restored_flags <= state == POP_FLAGS ? mem_data[2:0] : restored_flags;
      stack_fault <= fault_n;
    end
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:       state_n = start && !fault_n ? first_state(start_op) : IDLE;
      PUSH_PC_HI: state_n = PUSH_PC_LO;
      PUSH_PC_LO: state_n = op_q == OP_INT ? PUSH_FLAGS : IDLE;
      POP_FLAGS:  state_n = POP_PC_LO;
      POP_PC_LO:  state_n = POP_PC_HI;
      POP_PC_HI:  state_n = RESTORE;
      default:    state_n = IDLE;
    endcase
    memory_push = state inside {PUSH_PC_HI, PUSH_PC_LO, PUSH_FLAGS};
    memory_pop = state inside {POP_FLAGS, POP_PC_LO, POP_PC_HI};
    memory_write = memory_push;
    memory_read = memory_pop;
    memory_address_select = memory_push || memory_pop ? ADDR_SP : ADDR_NONE;
    memory_write_src_select = state == PUSH_PC_HI ? SRC_PC_HI : state == PUSH_PC_LO ? SRC_PC_LO : SRC_FLAGS;
    interrupt = state == PUSH_FLAGS;
    pc_choose_memory = state == RESTORE;
    flags_restore = state == RESTORE && op_q == OP_RTI;
    stall = state != IDLE;
  end
endmodule
